// File: rtl/uart_rx_odd_parity_pkg.sv
// Shared encodings for the UART receive front end: FSM states and frame geometry.
package uart_rx_odd_parity_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    START  = S_START,
    DATA   = S_DATA,
    PARITY = S_PARITY,
    STOP   = S_STOP
  } state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter: half_tick marks the start-bit midpoint, full_tick each later mid-bit.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt;

  assign half_tick = (clk_cnt == CW'(HALF - 1));
  assign full_tick = (clk_cnt == CW'(CLKS_PER_BIT - 1));

  // Wraps on full_tick so consecutive bits stay one period apart without reloads.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                clk_cnt <= '0;
    else if (clear || full_tick)   clk_cnt <= '0;
    else                           clk_cnt <= clk_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_odd_parity.sv
// UART receiver (8 data bits, one parity bit, one stop bit) with parity and framing checks.
module uart_rx_odd_parity
  import uart_rx_odd_parity_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9_600,
  parameter int PARITY_ODD = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;

  state_t      state;
  logic [1:0]  sync;
  logic        rx_s, rx_q;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        p_bit;
  logic        half_tick, full_tick, clear;

  assign rx_s  = sync[1];
  // Counter held at zero while idle so START always begins from a clean count.
  assign clear = (state == IDLE) || (state == START && half_tick);

  uart_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (clear),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync       <= 2'b11;
      rx_q       <= 1'b1;
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      p_bit      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      sync     <= {sync[0], rx};
      rx_q     <= rx_s;
      rx_valid <= 1'b0;
      case (state)
        IDLE: if (rx_q && !rx_s) state <= START;
        START: if (half_tick) begin
          if (rx_s) state <= IDLE;
          else begin
            state   <= DATA;
            bit_idx <= '0;
            rx_busy <= 1'b1;
          end
        end
        DATA: if (full_tick) begin
          shreg[bit_idx] <= rx_s;
          bit_idx        <= bit_idx + 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) state <= PARITY;
        end
        PARITY: if (full_tick) begin
          p_bit <= rx_s;
          state <= STOP;
        end
        STOP: if (full_tick) begin
          // Byte is delivered even on a bad stop bit; frame_err tells the consumer.
          rx_data    <= shreg;
          rx_valid   <= 1'b1;
          frame_err  <= ~rx_s;
          parity_err <= (^{shreg, p_bit}) != (PARITY_ODD != 0);
          rx_busy    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
